alu_input_seq: RTL and testbench



---
 rtl/alu_input_seq_pkg.sv | 24 ++
 rtl/alu_input_seq_if.sv | 33 +++
 rtl/alu_input_seq_key_debounce.sv | 63 ++++++
 rtl/alu_input_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_input_seq.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_input_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_input_seq_pkg
// Description : Shared definitions for the ALU input sequencer: the entry
//               state encoding (also shown on the display as "stage") and
//               the key index assignment on the key_n bus.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_input_seq_pkg;

  // Entry sequence states; the encoding is visible externally on stage.
  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_OP    = 2'd2,
    S_ISSUE = 2'd3
  } state_e;

  // Bit positions of the two push keys on key_n.
  localparam int unsigned KEY_ENTER = 0;
  localparam int unsigned KEY_CLEAR = 1;

endpackage : alu_input_seq_pkg
`default_nettype wire

// File: rtl/alu_input_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_input_seq_if
// Description : Operation bus from the input sequencer to the ALU core.
//               Valid/ready handshake carrying two operands and an opcode.
// Ports       : op_a, op_b   - operands (DATA_W)
//               op_code      - opcode (OP_W)
//               op_valid     - operation offered
//               op_ready     - ALU accepts the operation
//               master: sequencer side, slave: ALU side
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_input_seq_if #(
  parameter int DATA_W = 10,
  parameter int OP_W   = 4
) ();
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [OP_W-1:0]   op_code;
  logic              op_valid;
  logic              op_ready;

  modport master (
    output op_a, op_b, op_code, op_valid,
    input  op_ready
  );

  modport slave (
    input  op_a, op_b, op_code, op_valid,
    output op_ready
  );
endinterface : alu_input_seq_if
`default_nettype wire

// File: rtl/alu_input_seq_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Debouncer for one active-low push key. The raw key is
//               sampled on each tick into a DEB_SAMPLES-deep history; the
//               debounced state changes only when the whole history agrees.
//               A single press pulse is produced per press, none on release.
// Ports       : clk, rst_n  - clock, async active-low reset
//               tick_i      - sample strobe (one clk wide)
//               key_n_i     - raw key, active-low
//               level_o     - debounced state, 1 = pressed
//               press_o     - one-clk pulse on the released->pressed change
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  logic [DEB_SAMPLES-1:0] hist_q, hist_d;
  logic                   pressed_q, pressed_d;
  logic                   press_q, press_d;

  always_comb begin
    hist_d    = hist_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    if (tick_i) begin
      hist_d = {hist_q[DEB_SAMPLES-2:0], key_n_i};
    end
    // The history is judged from its registered value, so the state and the
    // pulse update together one clk after the history settles.
    if (hist_q == {DEB_SAMPLES{1'b0}}) begin
      pressed_d = 1'b1;
      press_d   = ~pressed_q;
    end else if (hist_q == {DEB_SAMPLES{1'b1}}) begin
      pressed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= {DEB_SAMPLES{1'b1}};
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
    end
  end

  assign level_o = pressed_q;
  assign press_o = press_q;

endmodule : key_debounce
`default_nettype wire

// File: rtl/alu_input_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_input_seq
// Description : Board user-input sequencer. Debounces the enter and clear
//               keys, steps through capture of operand A, operand B and the
//               opcode from the slide switches, then offers the operation
//               to the ALU over a valid/ready handshake.
// Ports       : clk, rst_n  - clock, async active-low reset
//               clk_cnt     - shared free-running counter (tick source)
//               key_n       - raw keys, active-low ([0]=enter, [1]=clear)
//               sw          - raw slide switches
//               alu_bus     - operation bus to the ALU (master)
//               stage       - current entry state, for the display
//               leds        - entry echo (0 unless echo enabled)
// Options     : ALU_INPUT_SEQ_ECHO_EN - registered switch/state echo on leds
// Revision    : 1.0 - initial release
// ============================================================================
module alu_input_seq
  import alu_input_seq_pkg::*;
#(
  parameter int DATA_W      = 10,
  parameter int OP_W        = 4,
  parameter int TICK_BIT    = 16,
  parameter int DEB_SAMPLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        clk_cnt,
  input  logic [1:0]         key_n,
  input  logic [DATA_W-1:0]  sw,
  alu_input_seq_if.master    alu_bus,
  output logic [1:0]         stage,
  output logic [DATA_W-1:0]  leds
);

  // -------------------------------------------------------------- tick ----
  logic tick_prev_q;
  logic armed_q;
  logic tick;

  // armed_q suppresses a tick in the first cycle after reset, when the
  // previous-value register has not yet seen the counter.
  assign tick = armed_q & clk_cnt[TICK_BIT] & ~tick_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      tick_prev_q <= clk_cnt[TICK_BIT];
      armed_q     <= 1'b1;
    end
  end

  // ----------------------------------------------------------- debounce ---
  logic [1:0] key_level;
  logic [1:0] key_press;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(
      .DEB_SAMPLES (DEB_SAMPLES)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_i  (tick),
      .key_n_i (key_n[k]),
      .level_o (key_level[k]),
      .press_o (key_press[k])
    );
  end

  logic unused_sig;
  assign unused_sig = ^{clk_cnt, key_level};

  logic enter, clear;
  assign enter = key_press[KEY_ENTER];
  assign clear = key_press[KEY_CLEAR];

  // ---------------------------------------------------------------- FSM ---
  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [OP_W-1:0]   op_code_q, op_code_d;

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    case (state_q)
      S_A, S_B, S_OP: begin
        // Clear takes priority over a simultaneous enter.
        if (clear) begin
          state_d   = S_A;
          op_a_d    = '0;
          op_b_d    = '0;
          op_code_d = '0;
        end else if (enter) begin
          case (state_q)
            S_A: begin
              op_a_d  = sw;
              state_d = S_B;
            end
            S_B: begin
              op_b_d  = sw;
              state_d = S_OP;
            end
            default: begin
              op_code_d = sw[OP_W-1:0];
              state_d   = S_ISSUE;
            end
          endcase
        end
      end
      S_ISSUE: begin
        // Keys are ignored here; only the handshake leaves this state.
        if (alu_bus.op_ready) begin
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_A;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
    end
  end

  // Valid is a pure decode of the registered state, so it rises with the
  // opcode capture and falls on the clk after acceptance.
  assign alu_bus.op_a     = op_a_q;
  assign alu_bus.op_b     = op_b_q;
  assign alu_bus.op_code  = op_code_q;
  assign alu_bus.op_valid = (state_q == S_ISSUE);
  assign stage            = state_q;

  // --------------------------------------------------------------- echo ---
`ifdef ALU_INPUT_SEQ_ECHO_EN
  logic [DATA_W-1:0] leds_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= '0;
    end else begin
      leds_q <= (state_q == S_ISSUE) ? {DATA_W{1'b1}} : sw;
    end
  end

  assign leds = leds_q;
`else
  assign leds = '0;
`endif

endmodule : alu_input_seq
`default_nettype wire

// File: tb/tb_alu_input_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_input_seq
// Description : Self-checking bench for alu_input_seq. A task-level model of
//               the entry sequence predicts stage and captured values after
//               each key press; issued operations are queued and a monitor
//               compares them against the bus at every handshake.
// Options     : ALU_INPUT_SEQ_ECHO_EN - also checks the leds echo
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_input_seq;

  localparam int DATA_W = 10;
  localparam int OP_W   = 4;

  logic              clk;
  logic              rst_n;
  logic [31:0]       clk_cnt;
  logic [1:0]        key_n;
  logic [DATA_W-1:0] sw;
  logic [1:0]        stage;
  logic [DATA_W-1:0] leds;

  alu_input_seq_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  alu_input_seq #(
    .DATA_W      (DATA_W),
    .OP_W        (OP_W),
    .TICK_BIT    (2),
    .DEB_SAMPLES (3)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_cnt (clk_cnt),
    .key_n   (key_n),
    .sw      (sw),
    .alu_bus (bus),
    .stage   (stage),
    .leds    (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) clk_cnt <= clk_cnt + 32'd1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } txn_t;

  txn_t sb_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model of the entry sequence.
  int                m_stage;
  logic [DATA_W-1:0] m_a, m_b;
  logic [OP_W-1:0]   m_op;

  bit  chk_drop = 1'b0;
  int  stage_changes = 0;
  logic [1:0] prev_stage = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_stage = 0;
    m_a     = '0;
    m_b     = '0;
    m_op    = '0;
  endtask

  task automatic check_state(input string name);
    check({name, "_stage"},   {30'd0, stage},           m_stage);
    check({name, "_valid"},   {31'd0, bus.op_valid},    (m_stage == 3) ? 1 : 0);
    check({name, "_op_a"},    {22'd0, bus.op_a},        {22'd0, m_a});
    check({name, "_op_b"},    {22'd0, bus.op_b},        {22'd0, m_b});
    check({name, "_op_code"}, {28'd0, bus.op_code},     {28'd0, m_op});
  endtask

  // Model update for one clean debounced press of enter and/or clear.
  task automatic model_press(input bit enter, input bit clr);
    if (clr && m_stage != 3) begin
      model_reset();
    end else if (enter) begin
      case (m_stage)
        0: begin m_a = sw; m_stage = 1; end
        1: begin m_b = sw; m_stage = 2; end
        2: begin
          m_op    = sw[OP_W-1:0];
          m_stage = 3;
          sb_q.push_back('{a: m_a, b: m_b, op: m_op});
        end
        default: ;
      endcase
    end
  endtask

  // A long, clean press followed by a long release: exactly one debounced
  // press per key involved.
  task automatic press(input bit enter, input bit clr);
    key_n = {~clr, ~enter};
    cyc(40);
    key_n = 2'b11;
    cyc(40);
    model_press(enter, clr);
  endtask

  task automatic accept(input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      cyc(1);
      check("valid_hold", {31'd0, bus.op_valid}, 1);
      check("op_a_hold", {22'd0, bus.op_a}, {22'd0, m_a});
    end
    bus.op_ready = 1'b1;
    cyc(1);
    bus.op_ready = 1'b0;
    m_stage = 0;
    cyc(2);
  endtask

  // Handshake monitor: compares each accepted operation with the queue and
  // confirms valid drops on the following clk.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_drop) begin
        check("valid_drop", {31'd0, bus.op_valid}, 0);
        check("stage_after_accept", {30'd0, stage}, 0);
        chk_drop = 1'b0;
      end
      if (bus.op_valid && bus.op_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_accept", 1, 0);
        end else begin
          txn_t t;
          t = sb_q.pop_front();
          check("acc_op_a",    {22'd0, bus.op_a},    {22'd0, t.a});
          check("acc_op_b",    {22'd0, bus.op_b},    {22'd0, t.b});
          check("acc_op_code", {28'd0, bus.op_code}, {28'd0, t.op});
        end
        chk_drop = 1'b1;
      end
      if (stage != prev_stage) stage_changes++;
      prev_stage = stage;
    end else begin
      prev_stage = 2'd0;
      chk_drop   = 1'b0;
    end
  end

`ifdef ALU_INPUT_SEQ_ECHO_EN
  logic [DATA_W-1:0] exp_leds;
  bit echo_armed = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      echo_armed = 1'b0;
    end else begin
      if (echo_armed) check("leds_echo", {22'd0, leds}, {22'd0, exp_leds});
      exp_leds   = (stage == 2'd3) ? {DATA_W{1'b1}} : sw;
      echo_armed = 1'b1;
    end
  end
`else
  always @(negedge clk) begin
    if (rst_n) check("leds_zero", {22'd0, leds}, 0);
  end
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    clk_cnt     = 32'd0;
    rst_n       = 1'b0;
    key_n       = 2'b11;
    sw          = '0;
    bus.op_ready = 1'b0;
    model_reset();
    cyc(5);
    rst_n = 1'b1;
    check_state("reset");

    // Idle with keys released: nothing moves.
    cyc(60);
    check_state("idle");
    check("idle_no_pulse", stage_changes, 0);

    // Enter held 40 clks with glitches either side: one step only.
    stage_changes = 0;
    sw = 10'h155;
    key_n[0] = 1'b0; cyc(2); key_n[0] = 1'b1; cyc(12);
    key_n[0] = 1'b0; cyc(40); key_n[0] = 1'b1; cyc(12);
    key_n[0] = 1'b0; cyc(2); key_n[0] = 1'b1; cyc(40);
    model_press(1'b1, 1'b0);
    check_state("glitch");
    check("glitch_one_step", stage_changes, 1);
    press(1'b0, 1'b1);
    check_state("clear_in_b");

    // Directed full sequence with a 20-clk ready stall.
    sw = 10'h2A5; press(1'b1, 1'b0);
    sw = 10'h013; press(1'b1, 1'b0);
    sw = 10'h006; press(1'b1, 1'b0);
    check_state("issue");
    accept(20);
    check_state("accepted");

    // Clear in S_OP zeroes everything; clear in S_ISSUE is ignored.
    sw = 10'h001; press(1'b1, 1'b0);
    sw = 10'h002; press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check_state("clear_in_op");
    sw = 10'h3FF; press(1'b1, 1'b0);
    sw = 10'h100; press(1'b1, 1'b0);
    sw = 10'h00F; press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check_state("clear_in_issue");
    sw = 10'h0AA; press(1'b1, 1'b0);
    check_state("enter_in_issue");
    accept(3);

    // Enter and clear together in S_B: clear wins, op_b not loaded.
    sw = 10'h0F0; press(1'b1, 1'b0);
    sw = 10'h30C; press(1'b1, 1'b1);
    check_state("enter_clear_b");

    // op_ready outside S_ISSUE has no effect.
    bus.op_ready = 1'b1;
    sw = 10'h111; press(1'b1, 1'b0);
    check_state("ready_outside_issue");
    bus.op_ready = 1'b0;
    press(1'b0, 1'b1);

    // Randomised transactions with occasional clears and random stalls.
    for (int t = 0; t < 8; t++) begin
      guard = 0;
      while (m_stage != 3 && guard < 20) begin
        sw = DATA_W'($urandom);
        if ($urandom_range(0, 5) == 0) press(1'b0, 1'b1);
        else                           press(1'b1, 1'b0);
        guard++;
      end
      check_state("rand_issue");
      accept($urandom_range(0, 10));
      check_state("rand_done");
    end

    // Asynchronous reset in S_ISSUE, mid-clk.
    sw = 10'h2A5; press(1'b1, 1'b0);
    sw = 10'h013; press(1'b1, 1'b0);
    sw = 10'h006; press(1'b1, 1'b0);
    check_state("pre_reset_issue");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus.op_valid}, 0);
    check("async_rst_stage", {30'd0, stage}, 0);
    check("async_rst_op_a", {22'd0, bus.op_a}, 0);
    check("async_rst_leds", {22'd0, leds}, 0);
    sb_q.delete();
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    check_state("post_reset");
    check("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_alu_input_seq
`default_nettype wire
